i2c_xfer_sched: RTL

- Host-side transaction scheduler that sits directly upstream of i2c_ctrl.
- Accepts transfer commands from the host: address, direction and byte count.
- Buffers write payload in a TX FIFO and read payload in an RX FIFO.
- Drives i2c_ctrl's start, direction, address, length and w_data inputs; consumes its r_data, byte_done and i2c_busy.

---
 rtl/i2c_xfer_sched_if.sv | 45 ++++
 rtl/i2c_xfer_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_sched_if.sv
// Bundle of host-side command/FIFO signals and the i2c_ctrl-facing signals of the scheduler.
// The slave modport is the scheduler's view; the master modport is the host/controller side.
interface i2c_xfer_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_full;
    logic [8:0] tx_level;
    logic       rx_rd_en;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [8:0] rx_level;
    logic       xfer_done;
    logic       err_len;
    logic       err_timeout;
    logic       tx_ovf;
    logic       ctl_go;
    logic       ctl_wr_ctrl;
    logic [6:0] ctl_slave_addr;
    logic [7:0] ctl_data_bytes;
    logic [7:0] ctl_w_data;
    logic [7:0] ctl_r_data;
    logic       ctl_busy;
    logic       ctl_byte_done;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, tx_wr_en, tx_wr_data, rx_rd_en,
               ctl_r_data, ctl_busy, ctl_byte_done,
        output cmd_ready, tx_full, tx_level, rx_rd_data, rx_empty, rx_level, xfer_done,
               err_len, err_timeout, tx_ovf, ctl_go, ctl_wr_ctrl, ctl_slave_addr,
               ctl_data_bytes, ctl_w_data
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, tx_wr_en, tx_wr_data, rx_rd_en,
               ctl_r_data, ctl_busy, ctl_byte_done,
        input  cmd_ready, tx_full, tx_level, rx_rd_data, rx_empty, rx_level, xfer_done,
               err_len, err_timeout, tx_ovf, ctl_go, ctl_wr_ctrl, ctl_slave_addr,
               ctl_data_bytes, ctl_w_data
    );
endinterface

// File: rtl/i2c_xfer_sched.sv
// Host-side transaction scheduler feeding i2c_ctrl: command FSM plus TX/RX payload FIFOs.
// A transfer is launched only once its whole payload (write) or landing space (read) is available.
module i2c_xfer_sched #(
    parameter int DEPTH     = 16,
    parameter int GO_CYCLES = 2,
    parameter int START_TO  = 64
) (
    input logic             clk,
    input logic             rst_n,
    i2c_xfer_sched_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [8:0]  DEPTH_L = 9'(DEPTH);
    localparam logic [3:0]  GO_LAST = 4'(GO_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(START_TO - 1);

    typedef enum logic [2:0] {IDLE, CHECK, GO, WAIT_BUSY, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [3:0]      go_cnt;
    logic [15:0]     to_cnt;
    logic [7:0]      byte_cnt;
    logic            busy_q;
    logic            wr_q;
    logic [6:0]      addr_q;
    logic [7:0]      len_q;
    logic            go_q;
    logic            err_len_q;
    logic            err_to_q;
    logic            ovf_q;

    logic [7:0]      tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr;
    logic [8:0]      tx_cnt;
    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_ptr, rx_rd_ptr;
    logic [8:0]      rx_cnt;

    logic            len_bad, space_ok, timeout_c, cmd_ready_c, done_c;
    logic            byte_ok, tx_full_c, tx_push, tx_pop, rx_push, rx_pop;

    assign len_bad   = (len_q == 8'd0) || ({1'b0, len_q} > DEPTH_L);
    assign space_ok  = wr_q ? (tx_cnt >= {1'b0, len_q})
                            : ((DEPTH_L - rx_cnt) >= {1'b0, len_q});
    // Bytes beyond the commanded length are ignored so the CHECK reservation cannot be overrun.
    assign byte_ok   = (state == RUN) && bus.ctl_byte_done && (byte_cnt < len_q);
    assign tx_full_c = (tx_cnt == DEPTH_L);
    assign tx_pop    = byte_ok && wr_q && (tx_cnt != 9'd0);
    assign tx_push   = bus.tx_wr_en && (!tx_full_c || tx_pop);
    assign rx_push   = byte_ok && !wr_q && (rx_cnt != DEPTH_L);
    assign rx_pop    = bus.rx_rd_en && (rx_cnt != 9'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            go_cnt   <= '0;
            to_cnt   <= '0;
            byte_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            go_cnt   <= (state == GO) ? go_cnt + 4'd1 : 4'd0;
            to_cnt   <= (state == WAIT_BUSY) ? to_cnt + 16'd1 : 16'd0;
            busy_q   <= bus.ctl_busy;
            if (state == GO)
                byte_cnt <= '0;
            else if (byte_ok)
                byte_cnt <= byte_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx    = state;
        timeout_c   = 1'b0;
        cmd_ready_c = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid)
                    state_nx = CHECK;
            end
            CHECK: begin
                if (len_bad)
                    state_nx = IDLE;
                else if (space_ok)
                    state_nx = GO;
            end
            GO: begin
                if (go_cnt == GO_LAST)
                    state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.ctl_busy)
                    state_nx = RUN;
                else if (to_cnt == TO_LAST) begin
                    timeout_c = 1'b1;
                    state_nx  = IDLE;
                end
            end
            RUN: begin
                if (busy_q && !bus.ctl_busy)
                    state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Controller-facing command registers are loaded on acceptance and held until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            go_q      <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                wr_q   <= bus.cmd_wr;
                addr_q <= bus.cmd_addr;
                len_q  <= bus.cmd_len;
            end
            go_q      <= (state_nx == GO);
            err_len_q <= (state == CHECK) && len_bad;
            err_to_q  <= timeout_c;
            ovf_q     <= bus.tx_wr_en && tx_full_c && !tx_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + AW'(1);
            if (tx_push && !tx_pop)
                tx_cnt <= tx_cnt + 9'd1;
            else if (tx_pop && !tx_push)
                tx_cnt <= tx_cnt - 9'd1;
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + AW'(1);
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + 9'd1;
            else if (rx_pop && !rx_push)
                rx_cnt <= rx_cnt - 9'd1;
        end
    end

    // Storage arrays need no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= bus.tx_wr_data;
        if (rx_push)
            rx_mem[rx_wr_ptr] <= bus.ctl_r_data;
    end

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.tx_full        = tx_full_c;
    assign bus.tx_level       = tx_cnt;
    assign bus.rx_rd_data     = rx_mem[rx_rd_ptr];
    assign bus.rx_empty       = (rx_cnt == 9'd0);
    assign bus.rx_level       = rx_cnt;
    assign bus.xfer_done      = done_c;
    assign bus.err_len        = err_len_q;
    assign bus.err_timeout    = err_to_q;
    assign bus.tx_ovf         = ovf_q;
    assign bus.ctl_go         = go_q;
    assign bus.ctl_wr_ctrl    = wr_q;
    assign bus.ctl_slave_addr = addr_q;
    assign bus.ctl_data_bytes = len_q;
    assign bus.ctl_w_data     = tx_mem[tx_rd_ptr];
endmodule
